uart_prog_loader: RTL and testbench

// Writer side of the instruction memory: takes a byte stream from the UART receiver, assembles

---
 rtl/uart_prog_loader_if.sv | 11 +
 rtl/uart_prog_loader.sv | 168 ++++++++++++++++
 tb/tb_uart_prog_loader.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_prog_loader_if.sv
// Byte stream from the UART receiver and the BRAM port A write bus of the program loader.
interface uart_prog_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (output rx_valid, rx_data, input mem_we, mem_addr, mem_wdata);
  modport slave  (input rx_valid, rx_data, output mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/uart_prog_loader.sv
// Loads a length-prefixed, checksummed little-endian word image from the UART into BRAM port A
// and holds the core in reset until the whole image has been verified.
module uart_prog_loader #(
  parameter logic [31:0] ADDR_BASE      = 32'h0,
  parameter int unsigned MAX_WORDS      = 2048,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_prog_loader_if.slave bus,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERR} state_e;

  state_e             state_q, state_d;
  logic [7:0]         len_lo_q, len_lo_d;
  logic [15:0]        n_q, n_d;
  logic [15:0]        k_q, k_d;
  logic [1:0]         bidx_q, bidx_d;
  logic [23:0]        word_q, word_d;
  logic [7:0]         csum_q, csum_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [3:0]         mem_we_q, mem_we_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic               core_rst_n_q, core_rst_n_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [15:0]        len_new;

  always_comb begin
    state_d      = state_q;
    len_lo_d     = len_lo_q;
    n_d          = n_q;
    k_d          = k_q;
    bidx_d       = bidx_q;
    word_d       = word_q;
    csum_d       = csum_q;
    tmo_d        = '0;
    mem_we_d     = '0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    core_rst_n_d = core_rst_n_q;
    busy_d       = busy_q;
    done_d       = done_q;
    err_d        = err_q;
    len_new      = {bus.rx_data, len_lo_q};

    case (state_q)
      S_LEN_LO: if (bus.rx_valid) begin
        len_lo_d = bus.rx_data;
        busy_d   = 1'b1;
        state_d  = S_LEN_HI;
      end
      S_LEN_HI: if (bus.rx_valid) begin
        n_d = len_new;
        if (len_new == '0 || 32'(len_new) > MAX_WORDS) begin
          state_d = S_ERR;
          err_d   = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = S_DATA;
          k_d     = '0;
          bidx_d  = '0;
          csum_d  = '0;
        end
      end
      S_DATA: if (bus.rx_valid) begin
        csum_d = csum_q + bus.rx_data;
        bidx_d = bidx_q + 2'd1;
        case (bidx_q)
          2'd0: word_d[7:0]   = bus.rx_data;
          2'd1: word_d[15:8]  = bus.rx_data;
          2'd2: word_d[23:16] = bus.rx_data;
          default: begin
            // The write is registered here, so a strobe during the pulse cycle is a new byte.
            mem_we_d    = '1;
            mem_addr_d  = ADDR_BASE + 32'({k_q, 2'b00});
            mem_wdata_d = {bus.rx_data, word_q};
            k_d         = k_q + 16'd1;
            if (k_q == n_q - 16'd1) state_d = S_CSUM;
          end
        endcase
      end
      S_CSUM: if (bus.rx_valid) begin
        busy_d = 1'b0;
        if (bus.rx_data == csum_q) begin
          state_d      = S_DONE;
          done_d       = 1'b1;
          core_rst_n_d = 1'b1;
        end else begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end
      end
      S_ERR: if (bus.rx_valid) begin
        err_d      = 1'b0;
        len_lo_d   = bus.rx_data;
        busy_d     = 1'b1;
        mem_addr_d = ADDR_BASE;
        csum_d     = '0;
        state_d    = S_LEN_HI;
      end
      default: ;
    endcase

    if (!bus.rx_valid && (state_q == S_LEN_HI || state_q == S_DATA || state_q == S_CSUM)) begin
      tmo_d = tmo_q + 1'b1;
      if (tmo_d == TMO_W'(TIMEOUT_CYCLES)) begin
        state_d = S_ERR;
        err_d   = 1'b1;
        busy_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_LEN_LO;
      len_lo_q     <= '0;
      n_q          <= '0;
      k_q          <= '0;
      bidx_q       <= '0;
      word_q       <= '0;
      csum_q       <= '0;
      tmo_q        <= '0;
      mem_we_q     <= '0;
      mem_addr_q   <= ADDR_BASE;
      mem_wdata_q  <= '0;
      core_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      n_q          <= n_d;
      k_q          <= k_d;
      bidx_q       <= bidx_d;
      word_q       <= word_d;
      csum_q       <= csum_d;
      tmo_q        <= tmo_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      core_rst_n_q <= core_rst_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign core_rst_n    = core_rst_n_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: expected BRAM writes are queued as frames are built
// and matched against every mem_we pulse; status outputs are checked after each frame.
module tb_uart_prog_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic core_rst_n, busy, done, err;

  uart_prog_loader_if bus_if();

  uart_prog_loader #(
    .ADDR_BASE     (32'h0),
    .MAX_WORDS     (2048),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_if),
    .core_rst_n(core_rst_n),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] exp_a[$];
  logic [31:0] exp_d[$];
  logic [7:0]  tx[$];
  int unsigned wr_count = 0;
  logic [31:0] last_wr_addr = '0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Write monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus_if.mem_we !== 4'h0) begin
      wr_count++;
      last_wr_addr = bus_if.mem_addr;
      check_eq("wr_we", 32'(bus_if.mem_we), 32'hF);
      check_eq("wr_expected", 32'(exp_a.size() != 0), 32'd1);
      if (exp_a.size() != 0) begin
        check_eq("wr_addr", bus_if.mem_addr, exp_a.pop_front());
        check_eq("wr_data", bus_if.mem_wdata, exp_d.pop_front());
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus_if.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic build_frame(input int unsigned n, input int unsigned seed, input bit bad_csum);
    logic [7:0]  cs;
    logic [31:0] w;
    logic [15:0] n16;
    cs  = '0;
    n16 = 16'(n);
    tx.delete();
    tx.push_back(n16[7:0]);
    tx.push_back(n16[15:8]);
    for (int unsigned i = 0; i < n; i++) begin
      w = 32'(seed * 32'h0100_0193 + i * 32'h9E37_79B9);
      for (int unsigned b = 0; b < 4; b++) begin
        tx.push_back(w[8*b +: 8]);
        cs = cs + w[8*b +: 8];
      end
      exp_a.push_back(32'(i * 4));
      exp_d.push_back(w);
    end
    tx.push_back(bad_csum ? cs + 8'd1 : cs);
  endtask

  // Sends the first cnt bytes of tx with gap idle cycles after each strobe.
  task automatic send_tx(input int unsigned gap, input int unsigned cnt);
    for (int unsigned i = 0; i < cnt; i++) begin
      @(negedge clk);
      bus_if.rx_valid = 1'b1;
      bus_if.rx_data  = tx[i];
      repeat (gap) begin
        @(negedge clk);
        bus_if.rx_valid = 1'b0;
      end
    end
    @(negedge clk);
    bus_if.rx_valid = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic d, input logic e, input logic cr, input logic b);
    check_eq({tag, "_done"}, 32'(done), 32'(d));
    check_eq({tag, "_err"}, 32'(err), 32'(e));
    check_eq({tag, "_core_rst_n"}, 32'(core_rst_n), 32'(cr));
    check_eq({tag, "_busy"}, 32'(busy), 32'(b));
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_we"}, 32'(bus_if.mem_we), 32'h0);
    check_eq({tag, "_addr"}, bus_if.mem_addr, 32'h0);
    check_eq({tag, "_wdata"}, bus_if.mem_wdata, 32'h0);
    check_status(tag, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int unsigned got;
    bus_if.rx_valid = 1'b0;
    bus_if.rx_data  = '0;

    apply_reset();
    check_reset_values("reset");

    // 1-word load with the reference bytes
    tx = '{8'h01, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h28};
    exp_a.push_back(32'h0);
    exp_d.push_back(32'h0010_0513);
    send_tx(1, 7);
    repeat (2) @(negedge clk);
    check_status("one_word", 1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("one_word_drained", 32'(exp_a.size()), 32'd0);

    // DONE ignores further traffic
    wr_count = 0;
    tx = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
    send_tx(0, 7);
    repeat (2) @(negedge clk);
    check_eq("done_ignore_wr", wr_count, 32'd0);
    check_status("done_ignore", 1'b1, 1'b0, 1'b1, 1'b0);

    // Bad checksum, then good frame from ERR
    apply_reset();
    tx = '{8'h01, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h29};
    exp_a.push_back(32'h0);
    exp_d.push_back(32'h0010_0513);
    send_tx(1, 7);
    repeat (2) @(negedge clk);
    check_status("bad_csum", 1'b0, 1'b1, 1'b0, 1'b0);
    tx = '{8'h01, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h28};
    exp_a.push_back(32'h0);
    exp_d.push_back(32'h0010_0513);
    send_tx(1, 7);
    repeat (2) @(negedge clk);
    check_status("resend", 1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("resend_drained", 32'(exp_a.size()), 32'd0);

    // Length limits
    apply_reset();
    wr_count = 0;
    tx = '{8'h00, 8'h00};
    send_tx(0, 2);
    repeat (2) @(negedge clk);
    check_status("len_zero", 1'b0, 1'b1, 1'b0, 1'b0);
    tx = '{8'h01, 8'h08};
    send_tx(0, 2);
    repeat (2) @(negedge clk);
    check_status("len_2049", 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("len_err_no_wr", wr_count, 32'd0);
    build_frame(2048, 7, 1'b0);
    send_tx(0, 2 + 4 * 2048 + 1);
    repeat (2) @(negedge clk);
    check_status("len_2048", 1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("len_2048_count", wr_count, 32'd2048);
    check_eq("len_2048_last", last_wr_addr, 32'h1FFC);
    check_eq("len_2048_drained", 32'(exp_a.size()), 32'd0);

    // Timeout after two payload bytes
    apply_reset();
    wr_count = 0;
    tx = '{8'h01, 8'h00, 8'h11, 8'h22};
    send_tx(0, 4);
    check_status("tmo_pre", 1'b0, 1'b0, 1'b0, 1'b1);
    got = 0;
    for (int unsigned c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (err) begin
        got = c;
        break;
      end
    end
    check_eq("tmo_cycles", got, 32'd16);
    check_status("tmo", 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("tmo_no_wr", wr_count, 32'd0);

    // Back-to-back 2-word frame
    apply_reset();
    build_frame(2, 3, 1'b0);
    send_tx(0, 11);
    repeat (2) @(negedge clk);
    check_status("b2b", 1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("b2b_drained", 32'(exp_a.size()), 32'd0);

    // Reset mid-frame after word 0
    apply_reset();
    build_frame(2, 11, 1'b0);
    send_tx(1, 6);
    repeat (2) @(negedge clk);
    check_eq("mid_pending", 32'(exp_a.size()), 32'd1);
    check_eq("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_reset");
    exp_a.delete();
    exp_d.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    build_frame(2, 12, 1'b0);
    send_tx(1, 11);
    repeat (2) @(negedge clk);
    check_status("after_mid", 1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("after_mid_drained", 32'(exp_a.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
